// File: rtl/register_file_param.sv
// Parameterised register file with two combinational read ports, one write port,
// a hard-wired zero register and a post-reset clear sequence gating access.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module register_file_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              regWrite,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic              ready
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   clr_idx_q;
  logic                ready_q;
  logic [DATA_W-1:0]   regs_q [NREGS];

  logic                clear_en;
  logic                wr_en;

  // Clear sequence: one register per cycle from index 1 up to NREGS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_idx_q <= FIRST_IDX;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (clr_idx_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            clr_idx_q <= clr_idx_q + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign clear_en = (state_q == ST_CLEAR) && !rst;
  // A write in the reset cycle is dropped; ready_q alone also blocks writes during CLEAR.
  assign wr_en    = regWrite && ready_q && (rd != '0) && !rst;

  // NOTE: the storage array has no reset branch so it maps onto plain RAM/flops
  // without a reset net; the CLEAR sequence zeroes it instead. Entry 0 is never
  // written and never read, since its read value is muxed to zero.
  always_ff @(posedge clk) begin
    if (clear_en) begin
      regs_q[clr_idx_q] <= '0;
    end else if (wr_en) begin
      regs_q[rd] <= writeData;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = '0;
    if (ready_q && (addr != '0)) begin
      val = regs_q[addr];
`ifdef RF_BYPASS_EN
      if (wr_en && (rd == addr)) begin
        val = writeData;
      end
`endif
    end
    return val;
  endfunction

  // NOTE: each combinational output gets a default before any conditional
  // override, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    readData1 = '0;
    readData2 = '0;
    readData1 = read_port(rs);
    readData2 = read_port(rt);
  end

endmodule
